// File: rtl/rv_ops_pkg.sv
// Shared RV32I encoding constants: internal micro-op numbering (identical to
// the issue-stage decode), base opcodes, funct3/funct7 values and the FIFO
// entry layout.
package rv_ops_pkg;

    // Internal opcodes, 1..37; 0 and anything above 37 are illegal
    localparam logic [6:0] OP_LUI  = 7'd1,  OP_AUIPC = 7'd2,  OP_JAL  = 7'd3,  OP_JALR  = 7'd4;
    localparam logic [6:0] OP_BEQ  = 7'd5,  OP_BNE   = 7'd6,  OP_BLT  = 7'd7,  OP_BGE   = 7'd8;
    localparam logic [6:0] OP_BLTU = 7'd9,  OP_BGEU  = 7'd10;
    localparam logic [6:0] OP_LB   = 7'd11, OP_LH    = 7'd12, OP_LW   = 7'd13, OP_LBU   = 7'd14;
    localparam logic [6:0] OP_LHU  = 7'd15;
    localparam logic [6:0] OP_SB   = 7'd16, OP_SH    = 7'd17, OP_SW   = 7'd18;
    localparam logic [6:0] OP_ADDI = 7'd19, OP_SLTI  = 7'd20, OP_SLTIU = 7'd21, OP_XORI = 7'd22;
    localparam logic [6:0] OP_ORI  = 7'd23, OP_ANDI  = 7'd24, OP_SLLI = 7'd25, OP_SRLI  = 7'd26;
    localparam logic [6:0] OP_SRAI = 7'd27;
    localparam logic [6:0] OP_ADD  = 7'd28, OP_SUB   = 7'd29, OP_SLL  = 7'd30, OP_SLT   = 7'd31;
    localparam logic [6:0] OP_SLTU = 7'd32, OP_XORR  = 7'd33, OP_SRL  = 7'd34, OP_SRA   = 7'd35;
    localparam logic [6:0] OP_ORR  = 7'd36, OP_ANDR  = 7'd37;

    // RV32I base opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct3 values (shared across formats where the numbers coincide)
    localparam logic [2:0] F3_000 = 3'b000, F3_001 = 3'b001, F3_010 = 3'b010, F3_011 = 3'b011;
    localparam logic [2:0] F3_100 = 3'b100, F3_101 = 3'b101, F3_110 = 3'b110, F3_111 = 3'b111;

    // funct7 values
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Instruction layout selected by the micro-op
    typedef enum logic [2:0] {
        FMT_BAD, FMT_U, FMT_J, FMT_I, FMT_SH, FMT_B, FMT_S, FMT_R
    } fmt_e;

    // One FIFO entry
    typedef struct packed {
        logic        illegal;
        logic [31:0] inst;
    } enc_t;

endpackage

// File: rtl/inst_encoder_if.sv
// Producer/consumer signal bundle around the encoder FIFO.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never waits on ready, and ready never depends on valid in the
// same cycle.
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_op;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_illegal;
    logic [15:0] illegal_cnt;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rd, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_illegal, illegal_cnt
    );
endinterface

// File: rtl/inst_enc_comb.sv
// Purely combinational micro-op to RV32I machine word encoder.
// Fields a format does not carry are simply never placed in the word.
module inst_enc_comb
    import rv_ops_pkg::*;
(
    input  logic [6:0]  op,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    output enc_t        enc
);

    fmt_e       fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    // Select format/opcode/funct fields, then pack them into the word
    always_comb begin
        fmt = FMT_BAD;
        opc = '0;
        f3  = F3_000;
        f7  = F7_ZERO;
        case (op)
            OP_LUI:   begin fmt = FMT_U;  opc = OPC_LUI;                  end
            OP_AUIPC: begin fmt = FMT_U;  opc = OPC_AUIPC;                end
            OP_JAL:   begin fmt = FMT_J;  opc = OPC_JAL;                  end
            OP_JALR:  begin fmt = FMT_I;  opc = OPC_JALR;                 end
            OP_BEQ:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_000;  end
            OP_BNE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_001;  end
            OP_BLT:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_100;  end
            OP_BGE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_101;  end
            OP_BLTU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_110;  end
            OP_BGEU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_111;  end
            OP_LB:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_000;  end
            OP_LH:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_001;  end
            OP_LW:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_010;  end
            OP_LBU:   begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_100;  end
            OP_LHU:   begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_101;  end
            OP_SB:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = F3_000;  end
            OP_SH:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = F3_001;  end
            OP_SW:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = F3_010;  end
            OP_ADDI:  begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = F3_000;  end
            OP_SLTI:  begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = F3_010;  end
            OP_SLTIU: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = F3_011;  end
            OP_XORI:  begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = F3_100;  end
            OP_ORI:   begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = F3_110;  end
            OP_ANDI:  begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = F3_111;  end
            OP_SLLI:  begin fmt = FMT_SH; opc = OPC_OPIMM;  f3 = F3_001;  end
            OP_SRLI:  begin fmt = FMT_SH; opc = OPC_OPIMM;  f3 = F3_101;  end
            OP_SRAI:  begin fmt = FMT_SH; opc = OPC_OPIMM;  f3 = F3_101; f7 = F7_ALT; end
            OP_ADD:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_000;  end
            OP_SUB:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_000; f7 = F7_ALT; end
            OP_SLL:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_001;  end
            OP_SLT:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_010;  end
            OP_SLTU:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_011;  end
            OP_XORR:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_100;  end
            OP_SRL:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_101;  end
            OP_SRA:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_101; f7 = F7_ALT; end
            OP_ORR:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_110;  end
            OP_ANDR:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_111;  end
            default:  fmt = FMT_BAD;
        endcase

        enc.illegal = 1'b0;
        enc.inst    = '0;
        case (fmt)
            FMT_U:   enc.inst = {imm[31:12], rd, opc};
            FMT_J:   enc.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            FMT_I:   enc.inst = {imm[11:0], rs1, f3, rd, opc};
            FMT_SH:  enc.inst = {f7, imm[4:0], rs1, f3, rd, opc};
            FMT_B:   enc.inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
            FMT_S:   enc.inst = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
            FMT_R:   enc.inst = {f7, rs2, rs1, f3, rd, opc};
            default: enc.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Micro-op re-encoder feeding the commit-trace port: encodes at the input and
// buffers {illegal, inst} in a DEPTH-entry FIFO. No bypass when empty and no
// combinational ready path when full.
module inst_encoder
    import rv_ops_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    inst_encoder_if.slave  bus
);

    localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

    enc_t             enc_in;
    enc_t             mem [DEPTH];
    enc_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [15:0]      illegal_cnt;
    logic             push;
    logic             pop;

    inst_enc_comb u_enc (
        .op  (bus.in_op),
        .rs1 (bus.in_rs1),
        .rs2 (bus.in_rs2),
        .rd  (bus.in_rd),
        .imm (bus.in_imm),
        .enc (enc_in)
    );

    // flush wins over both sides of the handshake
    assign push = bus.in_valid && bus.in_ready && !flush;
    assign pop  = bus.out_valid && bus.out_ready && !flush;

    assign head            = mem[rd_ptr];
    assign bus.in_ready    = (count != FULL);
    assign bus.out_valid   = (count != '0);
    assign bus.out_inst    = bus.out_valid ? head.inst : '0;
    assign bus.out_illegal = bus.out_valid && head.illegal;
    assign bus.illegal_cnt = illegal_cnt;

    // Storage array: written on push, contents qualified by count on read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc_in;
    end

    // Pointers and occupancy; flush returns the FIFO to empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Saturating count of accepted illegal micro-ops; survives flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (push && enc_in.illegal && (illegal_cnt != 16'hFFFF)) begin
            illegal_cnt <= illegal_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: fixed encodings, decode/re-encode round
// trip, illegal ops, full/backpressure, flush and asynchronous reset.
module tb_inst_encoder;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [6:0]  d_op;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic [31:0] d_imm;

    logic [31:0] rt_words [19] = '{
        32'h123452B7, 32'hABCDE517, 32'h008000EF, 32'hFFDFF06F, 32'hFFC08067,
        32'h00B51463, 32'hFE7FFEE3, 32'h0085A503, 32'hFFF4D283, 32'h00A12223,
        32'hFE508FA3, 32'hFFF00093, 32'h0015B513, 32'h01F29293, 32'h0042D293,
        32'h40B50533, 32'h40B55533, 32'h00B53533, 32'h00B57533
    };

    inst_encoder_if bus_if ();

    inst_encoder #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus_if)
    );

    // Clock: 10 ns period; all driving and sampling happens on the falling edge
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm);
        bus_if.in_op    = op;
        bus_if.in_rs1   = rs1;
        bus_if.in_rs2   = rs2;
        bus_if.in_rd    = rd;
        bus_if.in_imm   = imm;
        bus_if.in_valid = 1'b1;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] imm);
        drive(op, rs1, rs2, rd, imm);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp_inst, input logic exp_ill);
        check({tag, "_valid"}, 32'(bus_if.out_valid), 32'd1);
        check({tag, "_inst"}, bus_if.out_inst, exp_inst);
        check({tag, "_illegal"}, 32'(bus_if.out_illegal), 32'(exp_ill));
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
    endtask

    // Reference issue-stage decode: machine word -> micro-op fields
    task automatic decode(input logic [31:0] w, output logic [6:0] op, output logic [4:0] rs1,
                          output logic [4:0] rs2, output logic [4:0] rd, output logic [31:0] imm);
        logic [2:0] f3;
        logic       alt;
        f3  = w[14:12];
        alt = w[30];
        rs1 = w[19:15];
        rs2 = w[24:20];
        rd  = w[11:7];
        op  = 7'd0;
        imm = 32'd0;
        case (w[6:0])
            7'b0110111: begin op = 7'd1; imm = {w[31:12], 12'b0}; end
            7'b0010111: begin op = 7'd2; imm = {w[31:12], 12'b0}; end
            7'b1101111: begin op = 7'd3; imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; end
            7'b1100111: begin op = 7'd4; imm = {{20{w[31]}}, w[31:20]}; end
            7'b1100011: begin
                imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                case (f3)
                    3'd0: op = 7'd5;  3'd1: op = 7'd6;  3'd4: op = 7'd7;
                    3'd5: op = 7'd8;  3'd6: op = 7'd9;  3'd7: op = 7'd10;
                    default: op = 7'd0;
                endcase
            end
            7'b0000011: begin
                imm = {{20{w[31]}}, w[31:20]};
                case (f3)
                    3'd0: op = 7'd11; 3'd1: op = 7'd12; 3'd2: op = 7'd13;
                    3'd4: op = 7'd14; 3'd5: op = 7'd15;
                    default: op = 7'd0;
                endcase
            end
            7'b0100011: begin
                imm = {{20{w[31]}}, w[31:25], w[11:7]};
                case (f3)
                    3'd0: op = 7'd16; 3'd1: op = 7'd17; 3'd2: op = 7'd18;
                    default: op = 7'd0;
                endcase
            end
            7'b0010011: begin
                imm = {{20{w[31]}}, w[31:20]};
                case (f3)
                    3'd0: op = 7'd19; 3'd2: op = 7'd20; 3'd3: op = 7'd21;
                    3'd4: op = 7'd22; 3'd6: op = 7'd23; 3'd7: op = 7'd24;
                    3'd1: begin op = 7'd25; imm = {27'd0, w[24:20]}; end
                    default: begin op = alt ? 7'd27 : 7'd26; imm = {27'd0, w[24:20]}; end
                endcase
            end
            7'b0110011: begin
                case (f3)
                    3'd0: op = alt ? 7'd29 : 7'd28;
                    3'd1: op = 7'd30; 3'd2: op = 7'd31; 3'd3: op = 7'd32; 3'd4: op = 7'd33;
                    3'd5: op = alt ? 7'd35 : 7'd34;
                    3'd6: op = 7'd36;
                    default: op = 7'd37;
                endcase
            end
            default: op = 7'd0;
        endcase
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_op     = 7'd0;
        bus_if.in_rs1    = 5'd0;
        bus_if.in_rs2    = 5'd0;
        bus_if.in_rd     = 5'd0;
        bus_if.in_imm    = 32'd0;
        bus_if.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("rst_out_inst", bus_if.out_inst, 32'd0);
        check("rst_out_illegal", 32'(bus_if.out_illegal), 32'd0);
        check("rst_illegal_cnt", 32'(bus_if.illegal_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // lui: nothing visible before the push edge, entry visible one cycle later
        drive(7'd1, 5'd0, 5'd0, 5'd5, 32'h12345000);
        check("no_bypass", 32'(bus_if.out_valid), 32'd0);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        pop_check("lui", 32'h123452B7, 1'b0);

        // Hand-encoded branch, jal and arithmetic shift
        send(7'd5, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC);
        pop_check("beq", 32'hFE208EE3, 1'b0);
        send(7'd3, 5'd0, 5'd0, 5'd1, 32'd8);
        pop_check("jal", 32'h008000EF, 1'b0);
        send(7'd27, 5'd3, 5'd0, 5'd3, 32'd4);
        pop_check("srai", 32'h4041D193, 1'b0);

        // Round trip through the reference decode
        for (int i = 0; i < 19; i++) begin
            decode(rt_words[i], d_op, d_rs1, d_rs2, d_rd, d_imm);
            send(d_op, d_rs1, d_rs2, d_rd, d_imm);
            pop_check($sformatf("rt%0d", i), rt_words[i], 1'b0);
        end

        // Illegal opcodes below and above the legal range
        send(7'd0, 5'd1, 5'd2, 5'd3, 32'hFFFFFFFF);
        send(7'd40, 5'd4, 5'd5, 5'd6, 32'h12345678);
        check("illegal_cnt_2", 32'(bus_if.illegal_cnt), 32'd2);
        pop_check("ill_op0", 32'd0, 1'b1);
        pop_check("ill_op40", 32'd0, 1'b1);

        // Fill to DEPTH with addi x1,x0,k
        for (int k = 1; k <= DEPTH; k++) send(7'd19, 5'd0, 5'd0, 5'd1, 32'(k));
        check("full_in_ready", 32'(bus_if.in_ready), 32'd0);
        check("full_count", 32'(dut.count), 32'd4);
        check("full_head", bus_if.out_inst, 32'h00100093);
        // Fifth push held off, head stable
        drive(7'd19, 5'd0, 5'd0, 5'd1, 32'd5);
        @(negedge clk);
        check("held_head", bus_if.out_inst, 32'h00100093);
        check("held_in_ready", 32'(bus_if.in_ready), 32'd0);
        check("held_count", 32'(dut.count), 32'd4);
        // Pop only (still full at the edge), then push+pop together
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        check("drain1_inst", bus_if.out_inst, 32'h00200093);
        check("drain1_count", 32'(dut.count), 32'd3);
        check("drain1_in_ready", 32'(bus_if.in_ready), 32'd1);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        check("pushpop_inst", bus_if.out_inst, 32'h00300093);
        check("pushpop_count", 32'(dut.count), 32'd3);
        @(negedge clk);
        check("drain3_inst", bus_if.out_inst, 32'h00400093);
        @(negedge clk);
        check("drain4_inst", bus_if.out_inst, 32'h00500093);
        check("drain4_count", 32'(dut.count), 32'd1);
        @(negedge clk);
        check("drained_valid", 32'(bus_if.out_valid), 32'd0);
        bus_if.out_ready = 1'b0;

        // Flush while full, with an illegal push in the same cycle
        for (int k = 1; k <= DEPTH; k++) send(7'd19, 5'd0, 5'd0, 5'd1, 32'(k));
        drive(7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        bus_if.out_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.out_ready = 1'b0;
        check("flush_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("flush_count", 32'(dut.count), 32'd0);
        check("flush_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("flush_out_inst", bus_if.out_inst, 32'd0);
        check("flush_illegal_cnt", 32'(bus_if.illegal_cnt), 32'd2);
        send(7'd19, 5'd0, 5'd0, 5'd1, 32'd9);
        pop_check("post_flush", 32'h00900093, 1'b0);

        // Asynchronous reset mid-stream
        send(7'd19, 5'd0, 5'd0, 5'd1, 32'd1);
        send(7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        check("pre_rst_illegal_cnt", 32'(bus_if.illegal_cnt), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("arst_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("arst_out_inst", bus_if.out_inst, 32'd0);
        check("arst_out_illegal", 32'(bus_if.out_illegal), 32'd0);
        check("arst_illegal_cnt", 32'(bus_if.illegal_cnt), 32'd0);
        check("arst_count", 32'(dut.count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(bus_if.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
